// File: rtl/regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// regfile_write_arbiter : round-robin arbiter sharing the register-file write
// port between ALU and load writeback. Optional: RF_ARB_CONFLICT_CNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [31:0] rf_we,
  output logic [31:0] rf_wd
`ifdef RF_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [31:0] C_ONE = 32'd1;

  logic        r_prio;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        w_conflict;

  // Ready is forced low while reset is asserted so nothing handshakes into a
  // register that is being cleared.
  assign w_conflict = reset & ~hold & req0_valid & req1_valid;
  assign w_gnt0     = reset & ~hold & req0_valid & (~req1_valid | ~r_prio);
  assign w_gnt1     = reset & ~hold & req1_valid & (~req0_valid |  r_prio);
  assign w_accept   = w_gnt0 | w_gnt1;
  assign w_rd       = w_gnt1 ? req1_rd   : req0_rd;
  assign w_data     = w_gnt1 ? req1_data : req0_data;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we <= 32'd0;
      rf_wd <= 32'd0;
    end else begin
      rf_we <= 32'd0;
      if (w_accept) begin
        rf_wd <= w_data;
        // x0 is hardwired zero: the handshake completes but no enable fires.
        if (w_rd != 5'd0) begin
          rf_we <= C_ONE << w_rd;
        end
      end
    end
  end

`ifdef RF_ARB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  logic w_unused;
  assign w_unused = w_conflict;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// tb_regfile_write_arbiter : directed self-checking bench for the arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_rd = 5'd0;
  logic [31:0] req0_data = 32'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_rd = 5'd0;
  logic [31:0] req1_data = 32'd0;
  logic        req1_ready;
  logic [31:0] rf_we;
  logic [31:0] rf_wd;
`ifdef RF_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd)
`ifdef RF_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Wait for the active edge, then sample just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_we", rf_we, 32'd0);
    check_val("rst_wd", rf_wd, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_val("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    check_val("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    @(negedge clock);
    reset = 1'b1;

    // Single write to x5
    @(negedge clock);
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check_val("single_rdy0", {31'd0, req0_ready}, 32'd1);
    check_val("single_rdy1", {31'd0, req1_ready}, 32'd0);
    step();
    check_val("single_we", rf_we, 32'h00000020);
    check_val("single_wd", rf_wd, 32'hDEADBEEF);
    req0_valid = 1'b0;
    step();
    check_val("single_we_pulse", rf_we, 32'd0);
    check_val("single_wd_hold", rf_wd, 32'hDEADBEEF);

    // x0 suppression (prio is now 1)
    @(negedge clock);
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
    #1;
    check_val("x0_rdy1", {31'd0, req1_ready}, 32'd1);
    step();
    check_val("x0_we", rf_we, 32'd0);
    check_val("x0_wd", rf_wd, 32'h1234);
    req1_valid = 1'b0;

    // Conflict round-robin, prio back to 0
    @(negedge clock);
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("rr_rdy0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("rr_rdy1_%0d", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      check_val($sformatf("rr_we_%0d", i), rf_we, (i % 2 == 0) ? 32'h2 : 32'h4);
      check_val($sformatf("rr_wd_%0d", i), rf_wd, (i % 2 == 0) ? 32'hA0 : 32'hB1);
      @(negedge clock);
    end
`ifdef RF_ARB_CONFLICT_CNT_EN
    check_val("rr_cnt", {16'd0, conflict_cnt}, 32'd4);
`endif

    // Hold with both valid
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("hold_rdy0_%0d", i), {31'd0, req0_ready}, 32'd0);
      check_val($sformatf("hold_rdy1_%0d", i), {31'd0, req1_ready}, 32'd0);
      step();
      check_val($sformatf("hold_we_%0d", i), rf_we, 32'd0);
      @(negedge clock);
    end
`ifdef RF_ARB_CONFLICT_CNT_EN
    check_val("hold_cnt", {16'd0, conflict_cnt}, 32'd4);
`endif
    hold = 1'b0;
    #1;
    check_val("unhold_rdy0", {31'd0, req0_ready}, 32'd1);
    check_val("unhold_rdy1", {31'd0, req1_ready}, 32'd0);
    step();
    check_val("unhold_we", rf_we, 32'h2);

    // Reset mid-stream: prio=1 so req1 is accepted, then reset lands
    // before that write reaches the register file.
    @(negedge clock);
    step();
    check_val("pre_rst_we", rf_we, 32'h4);
    reset = 1'b0;
    #1;
    check_val("midrst_we", rf_we, 32'd0);
    check_val("midrst_wd", rf_wd, 32'd0);
    check_val("midrst_rdy0", {31'd0, req0_ready}, 32'd0);
    check_val("midrst_rdy1", {31'd0, req1_ready}, 32'd0);
`ifdef RF_ARB_CONFLICT_CNT_EN
    check_val("midrst_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    @(negedge clock);
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rel_rdy1", {31'd0, req1_ready}, 32'd1);
    check_val("rel_rdy0", {31'd0, req0_ready}, 32'd0);
    step();
    check_val("rel_we", rf_we, 32'h4);
    check_val("rel_wd", rf_wd, 32'hB1);

    // prio returned to 0 after the req1 accept
    @(negedge clock);
    req0_valid = 1'b1;
    #1;
    check_val("post_rel_rdy0", {31'd0, req0_ready}, 32'd1);

`ifdef RF_ARB_CONFLICT_CNT_EN
    // Saturation: conflict count starts at 1 from the cycle above
    repeat (70000) @(posedge clock);
    #1;
    check_val("sat_cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
    step();
    check_val("sat_nowrap", {16'd0, conflict_cnt}, 32'h0000FFFF);
`endif

    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write path of the 32-entry integer register file between two writeback requesters: ALU writeback (requester 0) and load-unit writeback (requester 1). Arbitrates round-robin, accepts one write per cycle via valid/ready handshake, and drives a registered one-hot write-enable vector and shared write-data bus to the 32 `Register32` instances. Register x0 is never written.

## Interface
Parameters:
- None.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  pipeline stall; when 1 no request is accepted.
- `req0_valid`  in  1  ALU writeback request.
- `req0_rd`  in  5  ALU destination register index.
- `req0_data`  in  32  ALU write data.
- `req0_ready`  out  1  requester 0 granted this cycle (combinational).
- `req1_valid`  in  1  load writeback request.
- `req1_rd`  in  5  load destination register index.
- `req1_data`  in  32  load write data.
- `req1_ready`  out  1  requester 1 granted this cycle (combinational).
- `rf_we`  out  32  registered one-hot write enable; bit n drives `we` of register n.
- `rf_wd`  out  32  registered write data, shared by all registers.
- `conflict_cnt`  out  16  saturating conflict counter (present only with `RF_ARB_CONFLICT_CNT_EN`).

## Operation
- State: priority pointer `prio` (1 bit), output registers `rf_we`/`rf_wd`, optional `conflict_cnt`.
- Grant logic (combinational, one grant max):
  - `hold`=1: both ready = 0.
  - Only one valid: that requester is granted.
  - Both valid: requester `prio` is granted; the other sees ready = 0. This is a conflict.
  - Neither valid: no grant; ready = 0 on both.
- Accept = valid && ready. Requester must hold valid, rd and data stable until accepted; the arbiter never drops a stalled request.
- On accept of requester i: `prio` <= 1-i (loser of next conflict is the last winner). No accept: `prio` unchanged.
- Output register on each edge:
  - Accept with rd≠0: `rf_we` <= one-hot(rd), `rf_wd` <= data.
  - Accept with rd=0: handshake completes, `rf_we` <= 0, `rf_wd` <= data. Bit 0 of `rf_we` is never 1.
  - No accept: `rf_we` <= 0, `rf_wd` holds its previous value.
- Both requesters targeting the same rd: serialized in grant order; the later write lands one cycle later and wins.
- Reset (asserted low, any time, including mid-handshake): `rf_we`=0, `rf_wd`=0, `prio`=0, `conflict_cnt`=0 immediately. A pending write not yet registered is discarded. A write already in `rf_we` but not yet clocked into the register file is also discarded. Ready outputs are 0 while reset is asserted.

## Timing
- Grant-to-ready: same cycle, combinational from valid/`hold`/`prio`.
- Accept-to-`rf_we`: 1 cycle (visible after the accepting edge).
- Accept-to-register-file update: 2 edges.
- `rf_we` is a single-cycle pulse per accepted write. Throughput is 1 write/cycle sustained.
- Worst-case wait for a continuously valid requester: 1 cycle after the other's grant, so there is no starvation.
- Release: first accept possible on the first rising edge after `reset` deasserts.

## Configuration
- `RF_ARB_CONFLICT_CNT_EN` defined:
  - `conflict_cnt` port and 16-bit counter exist.
  - The counter increments on every cycle with both valid, `hold`=0 and reset deasserted.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: port and counter absent. All other behaviour is identical.

## Test plan
- Reset: drive `reset`=0 mid-stream with both valid. Required: `rf_we`=0, `rf_wd`=0 and both ready=0 immediately. After release, req1 alone is granted first cycle.
- Single write: `req0_valid`=1, rd=5, data=32'hDEADBEEF. Required: `req0_ready`=1. Next cycle `rf_we`=32'h00000020, `rf_wd`=32'hDEADBEEF. The following cycle `rf_we`=0.
- Conflict round-robin: both valid continuously for 4 cycles after reset, rd0=1, rd1=2. Required:
  - Grants alternate 0,1,0,1.
  - `rf_we` sequence: 32'h2, 32'h4, 32'h2, 32'h4.
  - With macro, `conflict_cnt`=4.
- x0 suppression: `req1_valid`=1, rd=0, data=32'h1234. Required: `req1_ready`=1, next `rf_we`=0, `rf_wd`=32'h1234.
- Hold: both valid with `hold`=1 for 3 cycles, then `hold`=0. Required: no ready and `rf_we`=0 during hold, then grant to requester 0 (`prio`=0). With macro, `conflict_cnt` unchanged during hold.
- Saturation (macro only): force 70000 conflict cycles. Required: `conflict_cnt`=16'hFFFF, no wrap.
